// File: rtl/game_pkg.sv
// Shared types and encodings for the match controller and its full_game interface.
package game_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_CLR,
    S_RUN,
    S_SCORE,
    S_DONE
  } state_t;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_UP1 = 2'b00;
  localparam mode_t MODE_UP2 = 2'b01;
  localparam mode_t MODE_DN1 = 2'b10;
  localparam mode_t MODE_DN2 = 2'b11;

  localparam logic WHO_P0 = 1'b0;
  localparam logic WHO_P1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the grant is combinational, the pointer is registered.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // ptr = 0 favours requester 0 on contention
  logic ptr;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) begin
        gnt = ptr ? 2'b10 : 2'b01;
      end else begin
        gnt = req;
      end
    end
  end

  // After any grant the other requester gets priority next time.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (gnt[0]) begin
      ptr <= 1'b1;
    end else if (gnt[1]) begin
      ptr <= 1'b0;
    end
  end

endmodule

// File: rtl/game_match_ctrl.sv
// Match sequencer above full_game: loads each round, scores gameover/who, and
// arbitrates the shared control mode between two players while a round runs.
module game_match_ctrl
  import game_pkg::*;
#(
  parameter int ROUNDS_TO_WIN = 2,
  parameter int INIT_CYCLES   = 1,
  parameter int SCORE_W       = $clog2(ROUNDS_TO_WIN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [3:0]         seed,
  input  logic               p0_req,
  input  logic [1:0]         p0_mode,
  input  logic               p1_req,
  input  logic [1:0]         p1_mode,
  output logic               p0_gnt,
  output logic               p1_gnt,
  input  logic               gameover,
  input  logic               who,
  output logic               init,
  output logic [3:0]         initial_val,
  output logic [1:0]         control,
  output logic [SCORE_W-1:0] score0,
  output logic [SCORE_W-1:0] score1,
  output logic [3:0]         round_idx,
  output logic               busy,
  output logic               match_done,
  output logic               match_winner
);

  localparam int                 CNT_W     = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0]   INIT_LAST = CNT_W'(INIT_CYCLES - 1);
  localparam logic [SCORE_W-1:0] WIN       = SCORE_W'(ROUNDS_TO_WIN);

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s >= WIN) ? WIN : s + 1'b1;
  endfunction

  state_t             state, state_n;
  logic [3:0]         seed_q, seed_n;
  logic               who_q, who_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               win_n;
  logic [1:0]         arb_gnt;

  logic               p0_gnt_n, p1_gnt_n, init_n, busy_n, match_done_n, match_winner_n;
  logic [3:0]         initial_val_n, round_idx_n;
  logic [1:0]         control_n;
  logic [SCORE_W-1:0] score0_n, score1_n;

  // gameover in RUN takes priority, so the arbiter is held off on that cycle
  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .en  ((state == S_RUN) && !gameover),
    .req ({p1_req, p0_req}),
    .gnt (arb_gnt)
  );

  always_comb begin
    state_n        = state;
    seed_n         = seed_q;
    who_n          = who_q;
    cnt_n          = cnt;
    win_n          = 1'b0;
    p0_gnt_n       = 1'b0;
    p1_gnt_n       = 1'b0;
    init_n         = 1'b0;
    initial_val_n  = initial_val;
    control_n      = control;
    score0_n       = score0;
    score1_n       = score1;
    round_idx_n    = round_idx;
    busy_n         = busy;
    match_done_n   = match_done;
    match_winner_n = match_winner;

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_n       = S_LOAD;
          seed_n        = seed;
          score0_n      = '0;
          score1_n      = '0;
          round_idx_n   = 4'd0;
          cnt_n         = '0;
          init_n        = 1'b1;
          initial_val_n = seed;
          control_n     = MODE_UP1;
          busy_n        = 1'b1;
          match_done_n  = 1'b0;
        end
      end
      S_LOAD: begin
        if (cnt == INIT_LAST) begin
          state_n = S_WAIT_CLR;
        end else begin
          cnt_n  = cnt + 1'b1;
          init_n = 1'b1;
        end
      end
      S_WAIT_CLR: begin
        if (!gameover) begin
          state_n = S_RUN;
        end
      end
      S_RUN: begin
        if (gameover) begin
          who_n   = who;
          state_n = S_SCORE;
        end else if (arb_gnt[0]) begin
          p0_gnt_n  = 1'b1;
          control_n = p0_mode;
        end else if (arb_gnt[1]) begin
          p1_gnt_n  = 1'b1;
          control_n = p1_mode;
        end
      end
      S_SCORE: begin
        if (who_q == WHO_P0) begin
          score0_n = sat_inc(score0);
          win_n    = (score0_n == WIN);
        end else begin
          score1_n = sat_inc(score1);
          win_n    = (score1_n == WIN);
        end
        if (win_n) begin
          state_n        = S_DONE;
          match_done_n   = 1'b1;
          match_winner_n = who_q;
          busy_n         = 1'b0;
        end else begin
          state_n       = S_LOAD;
          round_idx_n   = round_idx + 4'd1;
          cnt_n         = '0;
          init_n        = 1'b1;
          initial_val_n = seed_q + round_idx_n;
          control_n     = MODE_UP1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      seed_q       <= 4'd0;
      who_q        <= 1'b0;
      cnt          <= '0;
      p0_gnt       <= 1'b0;
      p1_gnt       <= 1'b0;
      init         <= 1'b0;
      initial_val  <= 4'd0;
      control      <= MODE_UP1;
      score0       <= '0;
      score1       <= '0;
      round_idx    <= 4'd0;
      busy         <= 1'b0;
      match_done   <= 1'b0;
      match_winner <= 1'b0;
    end else begin
      state        <= state_n;
      seed_q       <= seed_n;
      who_q        <= who_n;
      cnt          <= cnt_n;
      p0_gnt       <= p0_gnt_n;
      p1_gnt       <= p1_gnt_n;
      init         <= init_n;
      initial_val  <= initial_val_n;
      control      <= control_n;
      score0       <= score0_n;
      score1       <= score1_n;
      round_idx    <= round_idx_n;
      busy         <= busy_n;
      match_done   <= match_done_n;
      match_winner <= match_winner_n;
    end
  end

endmodule

// File: tb/tb_game_match_ctrl.sv
// Bench for game_match_ctrl: scenario tasks plus a grant scoreboard fed by the stimulus.
module tb_game_match_ctrl;
  import game_pkg::*;

  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst, start, p0_req, p1_req, gameover, who;
  logic [3:0]    seed;
  logic [1:0]    p0_mode, p1_mode;
  logic          p0_gnt, p1_gnt, init, busy, match_done, match_winner;
  logic [3:0]    initial_val, round_idx;
  logic [1:0]    control;
  logic [SW-1:0] score0, score1;

  int checks   = 0;
  int failures = 0;

  // {who, mode} of each grant the stimulus expects, in order
  typedef logic [2:0] gnt_t;
  gnt_t exp_q[$];

  always #5 clk = ~clk;

  game_match_ctrl #(.ROUNDS_TO_WIN(2), .INIT_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed),
    .p0_req(p0_req), .p0_mode(p0_mode), .p1_req(p1_req), .p1_mode(p1_mode),
    .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .gameover(gameover), .who(who),
    .init(init), .initial_val(initial_val), .control(control),
    .score0(score0), .score1(score1), .round_idx(round_idx),
    .busy(busy), .match_done(match_done), .match_winner(match_winner)
  );

  always @(negedge clk) begin
    if (p0_gnt === 1'b1 || p1_gnt === 1'b1) begin
      gnt_t got, want;
      got = {p1_gnt, control};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL grant_unexpected got who/mode=%b required none", got);
      end else begin
        want = exp_q.pop_front();
        if ((p0_gnt === 1'b1 && p1_gnt === 1'b1) || got !== want) begin
          failures++;
          $display("FAIL grant_scoreboard got p0/p1=%b%b who/mode=%b required %b",
                   p0_gnt, p1_gnt, got, want);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; seed = 4'h5; gameover = 1'b0; who = 1'b0;
    p0_req = 1'b0; p1_req = 1'b0; p0_mode = 2'd0; p1_mode = 2'd0;
    repeat (2) @(negedge clk);
    checks++;
    if ({init, initial_val, control, score0, score1, round_idx, busy, match_done,
         match_winner, p0_gnt, p1_gnt} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got init=%b iv=%h ctl=%h s0=%0d s1=%0d rnd=%0d busy=%b done=%b required all 0",
               init, initial_val, control, score0, score1, round_idx, busy, match_done);
    end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, init} !== 2'b00) begin
      failures++;
      $display("FAIL start_during_rst got busy=%b init=%b required 0 0", busy, init);
    end
  endtask

  task automatic test_load();
    gameover = 1'b1; seed = 4'd7; start = 1'b1;
    @(negedge clk);
    checks++;
    if ({init, initial_val, control, busy} !== {1'b1, 4'd7, 2'd0, 1'b1}) begin
      failures++;
      $display("FAIL load_first got init=%b iv=%0d ctl=%0d busy=%b required 1 7 0 1",
               init, initial_val, control, busy);
    end
    start = 1'b0;
    p0_req = 1'b1; p1_req = 1'b1; p0_mode = 2'd2; p1_mode = 2'd3;
    exp_q.push_back({1'b0, 2'd2});
    exp_q.push_back({1'b1, 2'd3});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({init, p0_gnt, p1_gnt, score0, score1} !== '0) begin
        failures++;
        $display("FAIL wait_clr_hold[%0d] got init=%b gnt=%b%b s0=%0d s1=%0d required all 0",
                 i, init, p0_gnt, p1_gnt, score0, score1);
      end
    end
    gameover = 1'b0;
  endtask

  task automatic test_arbitration();
    logic [1:0] want;
    @(negedge clk);
    checks++;
    if ({p0_gnt, p1_gnt} !== 2'b00) begin
      failures++;
      $display("FAIL run_entry_no_gnt got %b%b required 00", p0_gnt, p1_gnt);
    end
    @(negedge clk);
    checks++;
    if (p0_gnt !== 1'b1 || control !== 2'd2) begin
      failures++;
      $display("FAIL contention_p0 got gnt=%b ctl=%0d required 1 2", p0_gnt, control);
    end
    p0_req = 1'b0;
    @(negedge clk);
    checks++;
    if (p1_gnt !== 1'b1 || control !== 2'd3) begin
      failures++;
      $display("FAIL single_p1 got gnt=%b ctl=%0d required 1 3", p1_gnt, control);
    end
    p0_req = 1'b1; p1_req = 1'b1; p0_mode = 2'd1; p1_mode = 2'd2;
    for (int i = 0; i < 4; i++) exp_q.push_back((i % 2 == 0) ? {1'b0, 2'd1} : {1'b1, 2'd2});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      want = (i % 2 == 0) ? 2'b10 : 2'b01;
      checks++;
      if ({p0_gnt, p1_gnt} !== want) begin
        failures++;
        $display("FAIL alternate[%0d] got p0/p1=%b%b required %b", i, p0_gnt, p1_gnt, want);
      end
    end
    p0_req = 1'b0; p1_req = 1'b0; p0_mode = 2'd3;
    @(negedge clk);
    checks++;
    if ({p0_gnt, p1_gnt, control} !== {2'b00, 2'd2}) begin
      failures++;
      $display("FAIL control_hold got gnt=%b%b ctl=%0d required 00 2", p0_gnt, p1_gnt, control);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL arb_grants_missing got pending=%0d required 0", exp_q.size());
    end
  endtask

  task automatic test_scoring();
    gameover = 1'b1; who = 1'b1; p0_req = 1'b1;
    @(negedge clk);
    checks++;
    if ({p0_gnt, score1, control} !== {1'b0, 2'd0, 2'd2}) begin
      failures++;
      $display("FAIL gameover_beats_req got gnt=%b s1=%0d ctl=%0d required 0 0 2", p0_gnt, score1, control);
    end
    @(negedge clk);
    checks++;
    if ({score1, round_idx, init, initial_val, control, p0_gnt} !== {2'd1, 4'd1, 1'b1, 4'd8, 2'd0, 1'b0}) begin
      failures++;
      $display("FAIL score_p1 got s1=%0d rnd=%0d init=%b iv=%0d ctl=%0d gnt=%b required 1 1 1 8 0 0",
               score1, round_idx, init, initial_val, control, p0_gnt);
    end
    @(negedge clk);
    checks++;
    if ({init, p0_gnt} !== 2'b00) begin
      failures++;
      $display("FAIL pending_req_outside_run got init=%b gnt=%b required 0 0", init, p0_gnt);
    end
    gameover = 1'b0; p0_req = 1'b0;
    @(negedge clk);
    gameover = 1'b1; who = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({score0, score1, round_idx, initial_val, init} !== {2'd1, 2'd1, 4'd2, 4'd9, 1'b1}) begin
      failures++;
      $display("FAIL score_p0 got s0=%0d s1=%0d rnd=%0d iv=%0d init=%b required 1 1 2 9 1",
               score0, score1, round_idx, initial_val, init);
    end
    gameover = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_mid_reset();
    p1_req = 1'b1; p1_mode = 2'd3;
    exp_q.push_back({1'b1, 2'd3});
    @(negedge clk);
    checks++;
    if ({p1_gnt, control, score0} !== {1'b1, 2'd3, 2'd1}) begin
      failures++;
      $display("FAIL pre_reset got gnt=%b ctl=%0d s0=%0d required 1 3 1", p1_gnt, control, score0);
    end
    p1_req = 1'b0; rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({control, score0, score1, round_idx, init, busy} !== '0) begin
      failures++;
      $display("FAIL mid_reset got ctl=%0d s0=%0d s1=%0d rnd=%0d init=%b busy=%b required all 0",
               control, score0, score1, round_idx, init, busy);
    end
    rst = 1'b0; start = 1'b1; seed = 4'hA;
    @(negedge clk);
    checks++;
    if ({init, initial_val} !== {1'b1, 4'hA}) begin
      failures++;
      $display("FAIL restart_load got init=%b iv=%h required 1 a", init, initial_val);
    end
    start = 1'b0; rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({init, busy} !== 2'b00) begin
      failures++;
      $display("FAIL reset_in_load got init=%b busy=%b required 0 0", init, busy);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_wrap_done();
    seed = 4'hF; who = 1'b1; gameover = 1'b0; start = 1'b1;
    @(negedge clk);
    checks++;
    if ({init, initial_val, round_idx} !== {1'b1, 4'hF, 4'd0}) begin
      failures++;
      $display("FAIL wrap_round0 got init=%b iv=%h rnd=%0d required 1 f 0", init, initial_val, round_idx);
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
    gameover = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({score1, initial_val, round_idx, init} !== {2'd1, 4'h0, 4'd1, 1'b1}) begin
      failures++;
      $display("FAIL wrap_round1 got s1=%0d iv=%h rnd=%0d init=%b required 1 0 1 1",
               score1, initial_val, round_idx, init);
    end
    @(negedge clk);
    gameover = 1'b0;
    @(negedge clk);
    gameover = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({match_done, match_winner, busy, score1, score0, init} !== {1'b1, 1'b1, 1'b0, 2'd2, 2'd0, 1'b0}) begin
      failures++;
      $display("FAIL match_done got done=%b win=%b busy=%b s1=%0d s0=%0d init=%b required 1 1 0 2 0 0",
               match_done, match_winner, busy, score1, score0, init);
    end
    gameover = 1'b0;
    @(negedge clk);
    checks++;
    if (match_done !== 1'b1) begin
      failures++;
      $display("FAIL done_held got %b required 1", match_done);
    end
    start = 1'b1; seed = 4'd3;
    @(negedge clk);
    checks++;
    if ({match_done, score1, score0, round_idx, init, initial_val, busy} !==
        {1'b0, 2'd0, 2'd0, 4'd0, 1'b1, 4'd3, 1'b1}) begin
      failures++;
      $display("FAIL restart_from_done got done=%b s1=%0d s0=%0d rnd=%0d init=%b iv=%0d busy=%b required 0 0 0 0 1 3 1",
               match_done, score1, score0, round_idx, init, initial_val, busy);
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_load();
    test_arbitration();
    test_scoring();
    test_mid_reset();
    test_wrap_done();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL grants_outstanding got pending=%0d required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
